// File: rtl/stream_arb_rsp_router_pkg.sv
// Shared width helpers for the arbiter response router and its ID queue.
package stream_arb_rsp_router_pkg;

  // Pointer width for a storage of `depth` entries; never collapses to zero bits.
  function automatic int unsigned ptr_width(input int unsigned depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

  // Width needed to count from 0 up to and including `max_val`.
  function automatic int unsigned cnt_width(input int unsigned max_val);
    return $clog2(max_val + 1);
  endfunction

endpackage

// File: rtl/stream_arb_rsp_router_fifo_v3.sv
// fifo_v3-compatible synchronous FIFO used as the in-order ID queue of the router.
module stream_arb_rsp_router_fifo_v3
  import stream_arb_rsp_router_pkg::*;
#(
  parameter bit          FALL_THROUGH = 1'b0,
  parameter int unsigned DATA_WIDTH   = 32,
  parameter int unsigned DEPTH        = 8,
  localparam int unsigned AddrW       = ptr_width(DEPTH),
  localparam int unsigned UsageW      = cnt_width(DEPTH)
) (
  input  logic                  clk_i,
  input  logic                  rst_ni,
  input  logic                  flush_i,
  input  logic                  testmode_i,
  output logic                  full_o,
  output logic                  empty_o,
  output logic [UsageW-1:0]     usage_o,
  input  logic [DATA_WIDTH-1:0] data_i,
  input  logic                  push_i,
  output logic [DATA_WIDTH-1:0] data_o,
  input  logic                  pop_i
);

  logic [AddrW-1:0]                 rd_ptr_q, rd_ptr_d;
  logic [AddrW-1:0]                 wr_ptr_q, wr_ptr_d;
  logic [UsageW-1:0]                cnt_q, cnt_d;
  logic [DEPTH-1:0][DATA_WIDTH-1:0] mem_q, mem_d;
  logic                             push_ok, pop_ok, bypass;
  logic                             unused_testmode;

  assign unused_testmode = testmode_i;

  function automatic logic [AddrW-1:0] ptr_inc(input logic [AddrW-1:0] p);
    return (p == AddrW'(DEPTH - 1)) ? '0 : p + AddrW'(1);
  endfunction

  // In fall-through mode an empty FIFO presents the incoming word directly.
  assign bypass  = FALL_THROUGH && (cnt_q == '0) && push_i;
  assign full_o  = (cnt_q == UsageW'(DEPTH));
  assign empty_o = (cnt_q == '0) && !bypass;
  assign usage_o = cnt_q;
  assign data_o  = bypass ? data_i : mem_q[rd_ptr_q];
  assign push_ok = push_i && !full_o;
  assign pop_ok  = pop_i && !empty_o;

  always_comb begin
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    cnt_d    = cnt_q;
    mem_d    = mem_q;
    if (push_ok) begin
      mem_d[wr_ptr_q] = data_i;
      wr_ptr_d        = ptr_inc(wr_ptr_q);
    end
    if (pop_ok) begin
      rd_ptr_d = ptr_inc(rd_ptr_q);
    end
    cnt_d = cnt_q + UsageW'(push_ok) - UsageW'(pop_ok);
    if (flush_i) begin
      rd_ptr_d = '0;
      wr_ptr_d = '0;
      cnt_d    = '0;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      cnt_q    <= '0;
      mem_q    <= '0;
    end else begin
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      cnt_q    <= cnt_d;
      mem_q    <= mem_d;
    end
  end

`ifndef SYNTHESIS
  assert property (@(posedge clk_i) disable iff (!rst_ni) cnt_q <= UsageW'(DEPTH));
`endif

endmodule

// File: rtl/stream_arb_rsp_router.sv
// Forwards arbitrated requests downstream, queues their source indices in order,
// and steers the in-order responses back to the issuing input.
module stream_arb_rsp_router
  import stream_arb_rsp_router_pkg::*;
#(
  parameter int unsigned NumInp  = 2,
  parameter int unsigned MaxTxns = 4,
  parameter type         req_t   = logic,
  parameter type         rsp_t   = logic,
  localparam int unsigned IdxW   = $clog2(NumInp),
  localparam int unsigned CntW   = cnt_width(MaxTxns)
) (
  input  logic                    clk_i,
  input  logic                    rst_ni,
  input  req_t                    slv_req_i,
  input  logic [IdxW-1:0]         slv_idx_i,
  input  logic                    slv_valid_i,
  output logic                    slv_ready_o,
  output req_t                    mst_req_o,
  output logic                    mst_valid_o,
  input  logic                    mst_ready_i,
  input  rsp_t                    mst_rsp_i,
  input  logic                    mst_rsp_valid_i,
  output logic                    mst_rsp_ready_o,
  output rsp_t [NumInp-1:0]       slv_rsp_o,
  output logic [NumInp-1:0]       slv_rsp_valid_o,
  input  logic [NumInp-1:0]       slv_rsp_ready_i,
  output logic [CntW-1:0]         outstanding_o,
  output logic                    idle_o
);

  typedef logic [IdxW-1:0] idx_t;

  idx_t            head_idx;
  logic            full, empty, push, pop;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic            idle_q, idle_d;
  logic [CntW-1:0] unused_usage;

  // Request path: pure pass-through, gated only by ID queue capacity.
  assign mst_req_o   = slv_req_i;
  assign mst_valid_o = slv_valid_i & ~full;
  assign slv_ready_o = mst_ready_i & ~full;
  assign push        = mst_valid_o & mst_ready_i;

  // Response path: the queue head selects which input sees the response.
  assign mst_rsp_ready_o = ~empty & slv_rsp_ready_i[head_idx];
  assign pop             = mst_rsp_valid_i & mst_rsp_ready_o;

  for (genvar g = 0; g < NumInp; g++) begin : g_rsp_lane
    assign slv_rsp_o[g] = mst_rsp_i;
  end

  always_comb begin
    slv_rsp_valid_o = '0;
    if (!empty) begin
      slv_rsp_valid_o[head_idx] = mst_rsp_valid_i;
    end
  end

  stream_arb_rsp_router_fifo_v3 #(
    .FALL_THROUGH (1'b0),
    .DATA_WIDTH   (IdxW),
    .DEPTH        (MaxTxns)
  ) i_id_queue (
    .clk_i      (clk_i),
    .rst_ni     (rst_ni),
    .flush_i    (1'b0),
    .testmode_i (1'b0),
    .full_o     (full),
    .empty_o    (empty),
    .usage_o    (unused_usage),
    .data_i     (slv_idx_i),
    .push_i     (push),
    .data_o     (head_idx),
    .pop_i      (pop)
  );

  // Outstanding counter; push and pop in the same cycle cancel.
  always_comb begin
    cnt_d = cnt_q;
    unique case ({push, pop})
      2'b10:   cnt_d = cnt_q + CntW'(1);
      2'b01:   cnt_d = cnt_q - CntW'(1);
      default: cnt_d = cnt_q;
    endcase
    idle_d = (cnt_d == '0);
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q  <= '0;
      idle_q <= 1'b1;
    end else begin
      cnt_q  <= cnt_d;
      idle_q <= idle_d;
    end
  end

  assign outstanding_o = cnt_q;
  assign idle_o        = idle_q;

`ifndef SYNTHESIS
  // Protocol checks on the surrounding stream handshakes.
  assert property (@(posedge clk_i) disable iff (!rst_ni) mst_rsp_valid_i |-> !empty);
  assert property (@(posedge clk_i) disable iff (!rst_ni)
                   slv_valid_i |-> (32'(slv_idx_i) < NumInp));
  assert property (@(posedge clk_i) disable iff (!rst_ni)
                   (slv_valid_i && !slv_ready_o) |=> slv_valid_i);
  assert property (@(posedge clk_i) disable iff (!rst_ni) cnt_q <= CntW'(MaxTxns));
`endif

endmodule

// File: tb/tb_stream_arb_rsp_router.sv
// Self-checking bench for stream_arb_rsp_router (NumInp=4, MaxTxns=4) against a queue model.
module tb_stream_arb_rsp_router;

  localparam int unsigned N = 4;
  localparam int unsigned M = 4;

  typedef logic [15:0] req_t;
  typedef logic [15:0] rsp_t;

  logic              clk_i = 1'b0;
  logic              rst_ni;
  req_t              slv_req_i;
  logic [1:0]        slv_idx_i;
  logic              slv_valid_i;
  logic              slv_ready_o;
  req_t              mst_req_o;
  logic              mst_valid_o;
  logic              mst_ready_i;
  rsp_t              mst_rsp_i;
  logic              mst_rsp_valid_i;
  logic              mst_rsp_ready_o;
  rsp_t [N-1:0]      slv_rsp_o;
  logic [N-1:0]      slv_rsp_valid_o;
  logic [N-1:0]      slv_rsp_ready_i;
  logic [2:0]        outstanding_o;
  logic              idle_o;

  int n_checks = 0;
  int n_pass   = 0;
  int model_ids[$];

  stream_arb_rsp_router #(
    .NumInp  (N),
    .MaxTxns (M),
    .req_t   (req_t),
    .rsp_t   (rsp_t)
  ) dut (
    .clk_i           (clk_i),
    .rst_ni          (rst_ni),
    .slv_req_i       (slv_req_i),
    .slv_idx_i       (slv_idx_i),
    .slv_valid_i     (slv_valid_i),
    .slv_ready_o     (slv_ready_o),
    .mst_req_o       (mst_req_o),
    .mst_valid_o     (mst_valid_o),
    .mst_ready_i     (mst_ready_i),
    .mst_rsp_i       (mst_rsp_i),
    .mst_rsp_valid_i (mst_rsp_valid_i),
    .mst_rsp_ready_o (mst_rsp_ready_o),
    .slv_rsp_o       (slv_rsp_o),
    .slv_rsp_valid_o (slv_rsp_valid_o),
    .slv_rsp_ready_i (slv_rsp_ready_i),
    .outstanding_o   (outstanding_o),
    .idle_o          (idle_o)
  );

  always #5 clk_i = ~clk_i;

  // Reference: a bounded in-order list of issuing indices, updated from handshakes at each edge.
  function automatic void model_edge();
    bit full;
    bit push;
    bit pop;
    if (!rst_ni) begin
      model_ids.delete();
      return;
    end
    full = (model_ids.size() == M);
    push = slv_valid_i && mst_ready_i && !full;
    pop  = 1'b0;
    if (model_ids.size() != 0) pop = mst_rsp_valid_i && slv_rsp_ready_i[model_ids[0]];
    if (pop) void'(model_ids.pop_front());
    if (push) model_ids.push_back(int'(slv_idx_i));
  endfunction

  task automatic tick();
    @(posedge clk_i);
    model_edge();
    #1;
  endtask

  task automatic drive_idle();
    slv_req_i       = '0;
    slv_idx_i       = '0;
    slv_valid_i     = 1'b0;
    mst_ready_i     = 1'b0;
    mst_rsp_i       = '0;
    mst_rsp_valid_i = 1'b0;
    slv_rsp_ready_i = '0;
  endtask

  task automatic push_one(input int idx);
    slv_valid_i = 1'b1;
    mst_ready_i = 1'b1;
    slv_idx_i   = 2'(idx);
    slv_req_i   = 16'($urandom);
    tick();
    slv_valid_i = 1'b0;
  endtask

  task automatic test_reset();
    rst_ni = 1'b0;
    drive_idle();
    tick();
    tick();
    rst_ni = 1'b1;
    tick();
    n_checks++; if (mst_valid_o !== 1'b0) $display("FAIL reset_mst_valid got %b exp 0", mst_valid_o); else n_pass++;
    n_checks++; if (slv_ready_o !== 1'b0) $display("FAIL reset_slv_ready got %b exp 0", slv_ready_o); else n_pass++;
    n_checks++; if (mst_rsp_ready_o !== 1'b0) $display("FAIL reset_rsp_ready got %b exp 0", mst_rsp_ready_o); else n_pass++;
    n_checks++; if (slv_rsp_valid_o !== 4'b0) $display("FAIL reset_rsp_valid got %b exp 0000", slv_rsp_valid_o); else n_pass++;
    n_checks++; if (outstanding_o !== 3'd0) $display("FAIL reset_outstanding got %0d exp 0", outstanding_o); else n_pass++;
    n_checks++; if (idle_o !== 1'b1) $display("FAIL reset_idle got %b exp 1", idle_o); else n_pass++;
  endtask

  task automatic test_in_order();
    int         idxs [3] = '{2, 0, 3};
    logic [3:0] exp_vec [3] = '{4'b0100, 4'b0001, 4'b1000};
    mst_ready_i = 1'b1;
    for (int i = 0; i < 3; i++) begin
      slv_valid_i = 1'b1;
      slv_idx_i   = 2'(idxs[i]);
      slv_req_i   = 16'($urandom);
      #1;
      n_checks++; if (mst_valid_o !== 1'b1) $display("FAIL order_mst_valid[%0d] got %b exp 1", i, mst_valid_o); else n_pass++;
      n_checks++; if (mst_req_o !== slv_req_i) $display("FAIL order_mst_req[%0d] got %h exp %h", i, mst_req_o, slv_req_i); else n_pass++;
      tick();
    end
    slv_valid_i = 1'b0;
    n_checks++; if (outstanding_o !== 3'd3) $display("FAIL order_outstanding_full got %0d exp 3", outstanding_o); else n_pass++;
    mst_rsp_valid_i = 1'b1;
    slv_rsp_ready_i = 4'hF;
    for (int i = 0; i < 3; i++) begin
      mst_rsp_i = 16'($urandom);
      #1;
      n_checks++; if (slv_rsp_valid_o !== exp_vec[i]) $display("FAIL order_rsp_valid[%0d] got %b exp %b", i, slv_rsp_valid_o, exp_vec[i]); else n_pass++;
      n_checks++; if (slv_rsp_o[idxs[i]] !== mst_rsp_i) $display("FAIL order_rsp_data[%0d] got %h exp %h", i, slv_rsp_o[idxs[i]], mst_rsp_i); else n_pass++;
      n_checks++; if (mst_rsp_ready_o !== 1'b1) $display("FAIL order_rsp_ready[%0d] got %b exp 1", i, mst_rsp_ready_o); else n_pass++;
      tick();
      n_checks++; if (outstanding_o !== 3'(2 - i)) $display("FAIL order_outstanding[%0d] got %0d exp %0d", i, outstanding_o, 2 - i); else n_pass++;
    end
    mst_rsp_valid_i = 1'b0;
    n_checks++; if (idle_o !== 1'b1) $display("FAIL order_idle got %b exp 1", idle_o); else n_pass++;
  endtask

  task automatic test_full();
    mst_ready_i = 1'b1;
    slv_valid_i = 1'b1;
    for (int i = 0; i < 4; i++) begin
      slv_idx_i = 2'($urandom_range(0, 3));
      slv_req_i = 16'($urandom);
      tick();
    end
    n_checks++; if (outstanding_o !== 3'd4) $display("FAIL full_outstanding got %0d exp 4", outstanding_o); else n_pass++;
    slv_idx_i = 2'd1;
    slv_req_i = 16'($urandom);
    #1;
    n_checks++; if (slv_ready_o !== 1'b0) $display("FAIL full_slv_ready got %b exp 0", slv_ready_o); else n_pass++;
    n_checks++; if (mst_valid_o !== 1'b0) $display("FAIL full_mst_valid got %b exp 0", mst_valid_o); else n_pass++;
    mst_rsp_valid_i = 1'b1;
    slv_rsp_ready_i = 4'hF;
    #1;
    n_checks++; if (mst_rsp_ready_o !== 1'b1) $display("FAIL full_pop_ready got %b exp 1", mst_rsp_ready_o); else n_pass++;
    n_checks++; if (slv_ready_o !== 1'b0) $display("FAIL full_stall_on_pop got %b exp 0", slv_ready_o); else n_pass++;
    tick();
    mst_rsp_valid_i = 1'b0;
    #1;
    n_checks++; if (slv_ready_o !== 1'b1) $display("FAIL full_after_pop_ready got %b exp 1", slv_ready_o); else n_pass++;
    n_checks++; if (mst_valid_o !== 1'b1) $display("FAIL full_after_pop_valid got %b exp 1", mst_valid_o); else n_pass++;
    n_checks++; if (outstanding_o !== 3'd3) $display("FAIL full_after_pop_out got %0d exp 3", outstanding_o); else n_pass++;
    tick();
    slv_valid_i = 1'b0;
    n_checks++; if (outstanding_o !== 3'd4) $display("FAIL full_refill_out got %0d exp 4", outstanding_o); else n_pass++;
    mst_rsp_valid_i = 1'b1;
    repeat (4) tick();
    mst_rsp_valid_i = 1'b0;
    n_checks++; if (outstanding_o !== 3'd0) $display("FAIL full_drain_out got %0d exp 0", outstanding_o); else n_pass++;
    n_checks++; if (idle_o !== 1'b1) $display("FAIL full_drain_idle got %b exp 1", idle_o); else n_pass++;
  endtask

  task automatic test_backpressure();
    push_one(1);
    push_one(2);
    mst_rsp_valid_i = 1'b1;
    slv_rsp_ready_i = 4'b1101;
    for (int i = 0; i < 3; i++) begin
      #1;
      n_checks++; if (mst_rsp_ready_o !== 1'b0) $display("FAIL bp_rsp_ready[%0d] got %b exp 0", i, mst_rsp_ready_o); else n_pass++;
      n_checks++; if (slv_rsp_valid_o !== 4'b0010) $display("FAIL bp_rsp_valid[%0d] got %b exp 0010", i, slv_rsp_valid_o); else n_pass++;
      tick();
      n_checks++; if (outstanding_o !== 3'd2) $display("FAIL bp_outstanding[%0d] got %0d exp 2", i, outstanding_o); else n_pass++;
    end
    slv_rsp_ready_i = 4'hF;
    #1;
    n_checks++; if (mst_rsp_ready_o !== 1'b1) $display("FAIL bp_release_ready got %b exp 1", mst_rsp_ready_o); else n_pass++;
    tick();
    n_checks++; if (slv_rsp_valid_o !== 4'b0100) $display("FAIL bp_next_head got %b exp 0100", slv_rsp_valid_o); else n_pass++;
    tick();
    mst_rsp_valid_i = 1'b0;
    n_checks++; if (outstanding_o !== 3'd0) $display("FAIL bp_drain_out got %0d exp 0", outstanding_o); else n_pass++;
  endtask

  task automatic test_push_pop();
    push_one(3);
    push_one(1);
    n_checks++; if (outstanding_o !== 3'd2) $display("FAIL pp_pre_out got %0d exp 2", outstanding_o); else n_pass++;
    slv_valid_i     = 1'b1;
    slv_idx_i       = 2'd2;
    mst_rsp_valid_i = 1'b1;
    slv_rsp_ready_i = 4'hF;
    #1;
    n_checks++; if (slv_rsp_valid_o !== 4'b1000) $display("FAIL pp_head got %b exp 1000", slv_rsp_valid_o); else n_pass++;
    n_checks++; if (mst_valid_o !== 1'b1) $display("FAIL pp_mst_valid got %b exp 1", mst_valid_o); else n_pass++;
    tick();
    slv_valid_i = 1'b0;
    n_checks++; if (outstanding_o !== 3'd2) $display("FAIL pp_post_out got %0d exp 2", outstanding_o); else n_pass++;
    n_checks++; if (slv_rsp_valid_o !== 4'b0010) $display("FAIL pp_second got %b exp 0010", slv_rsp_valid_o); else n_pass++;
    tick();
    n_checks++; if (slv_rsp_valid_o !== 4'b0100) $display("FAIL pp_third got %b exp 0100", slv_rsp_valid_o); else n_pass++;
    tick();
    mst_rsp_valid_i = 1'b0;
    n_checks++; if (outstanding_o !== 3'd0) $display("FAIL pp_drain_out got %0d exp 0", outstanding_o); else n_pass++;
  endtask

  task automatic test_reset_mid();
    push_one(0);
    push_one(3);
    push_one(2);
    n_checks++; if (outstanding_o !== 3'd3) $display("FAIL rst_mid_pre_out got %0d exp 3", outstanding_o); else n_pass++;
    mst_rsp_valid_i = 1'b1;
    slv_rsp_ready_i = 4'hF;
    rst_ni = 1'b0;
    model_ids.delete();
    #1;
    n_checks++; if (outstanding_o !== 3'd0) $display("FAIL rst_mid_async_out got %0d exp 0", outstanding_o); else n_pass++;
    tick();
    n_checks++; if (outstanding_o !== 3'd0) $display("FAIL rst_mid_out got %0d exp 0", outstanding_o); else n_pass++;
    n_checks++; if (idle_o !== 1'b1) $display("FAIL rst_mid_idle got %b exp 1", idle_o); else n_pass++;
    n_checks++; if (mst_rsp_ready_o !== 1'b0) $display("FAIL rst_mid_rsp_ready got %b exp 0", mst_rsp_ready_o); else n_pass++;
    n_checks++; if (slv_rsp_valid_o !== 4'b0) $display("FAIL rst_mid_rsp_valid got %b exp 0000", slv_rsp_valid_o); else n_pass++;
    mst_rsp_valid_i = 1'b0;
    rst_ni = 1'b1;
    tick();
    n_checks++; if (idle_o !== 1'b1) $display("FAIL rst_mid_release_idle got %b exp 1", idle_o); else n_pass++;
  endtask

  task automatic test_random();
    bit         hold = 1'b0;
    bit         full;
    logic       e_mval, e_sready, e_rready;
    logic [3:0] e_vec;
    for (int c = 0; c < 400; c++) begin
      if (!hold) begin
        slv_valid_i = ($urandom_range(0, 2) != 0);
        slv_idx_i   = 2'($urandom_range(0, 3));
        slv_req_i   = 16'($urandom);
      end
      mst_ready_i     = ($urandom_range(0, 3) != 0);
      mst_rsp_valid_i = (model_ids.size() != 0) && ($urandom_range(0, 1) == 1);
      slv_rsp_ready_i = 4'($urandom);
      mst_rsp_i       = 16'($urandom);
      #1;
      full     = (model_ids.size() == M);
      e_mval   = slv_valid_i && !full;
      e_sready = mst_ready_i && !full;
      e_vec    = 4'b0;
      e_rready = 1'b0;
      if (model_ids.size() != 0) begin
        if (mst_rsp_valid_i) e_vec = 4'(1) << model_ids[0];
        e_rready = slv_rsp_ready_i[model_ids[0]];
      end
      n_checks++; if (mst_valid_o !== e_mval) $display("FAIL rnd_mst_valid c%0d got %b exp %b", c, mst_valid_o, e_mval); else n_pass++;
      n_checks++; if (slv_ready_o !== e_sready) $display("FAIL rnd_slv_ready c%0d got %b exp %b", c, slv_ready_o, e_sready); else n_pass++;
      n_checks++; if (mst_req_o !== slv_req_i) $display("FAIL rnd_mst_req c%0d got %h exp %h", c, mst_req_o, slv_req_i); else n_pass++;
      n_checks++; if (slv_rsp_valid_o !== e_vec) $display("FAIL rnd_rsp_valid c%0d got %b exp %b", c, slv_rsp_valid_o, e_vec); else n_pass++;
      n_checks++; if (mst_rsp_ready_o !== e_rready) $display("FAIL rnd_rsp_ready c%0d got %b exp %b", c, mst_rsp_ready_o, e_rready); else n_pass++;
      n_checks++; if (slv_rsp_o !== {4{mst_rsp_i}}) $display("FAIL rnd_rsp_data c%0d got %h exp %h", c, slv_rsp_o, {4{mst_rsp_i}}); else n_pass++;
      n_checks++; if (outstanding_o !== 3'(model_ids.size())) $display("FAIL rnd_outstanding c%0d got %0d exp %0d", c, outstanding_o, model_ids.size()); else n_pass++;
      n_checks++; if (idle_o !== (model_ids.size() == 0)) $display("FAIL rnd_idle c%0d got %b exp %b", c, idle_o, model_ids.size() == 0); else n_pass++;
      hold = slv_valid_i && !e_sready;
      tick();
    end
    // Abandon any stalled request under reset so the valid-hold rule is not broken.
    rst_ni = 1'b0;
    drive_idle();
    tick();
    rst_ni = 1'b1;
    tick();
    n_checks++; if (outstanding_o !== 3'd0) $display("FAIL rnd_final_out got %0d exp 0", outstanding_o); else n_pass++;
  endtask

  initial begin
    test_reset();
    test_in_order();
    test_full();
    test_backpressure();
    test_push_pop();
    test_reset_mid();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
